n_ratio_detector: RTL and testbench
===================================

# n_ratio_detector

Measures the period and high time of a square wave produced by `n_divider` and recovers the 4-bit ratio code `n` that generated it. Sits on the receive/check side of the clock-division path: a divided clock from `n_divider` enters, and the detected ratio code with lock/error status leaves. It is used for self-check of the divider chain and for detecting ratio changes on an external divided clock.

## Interface
- `SYNC_STAGES`, 2: number of input synchronizer flops on `sig_in` (≥1).
- `TIMEOUT`, 1023: cycles without a rising edge before the block drops to IDLE (must exceed 512).
- `clk` input 1: system clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `sig_in` input 1: divided square wave to classify (may be asynchronous).
- `n_out` output 4: detected ratio code (0→20, 1→2, 2→4, … 9→512); holds last locked code.
- `valid` output 1: high while locked to a confirmed code.
- `err` output 1: high if the most recently completed period matched no legal ratio/duty.
- `no_signal` output 1: high while in IDLE (after reset or timeout).

## Operation
- Legal ratio table: D = 20 for n=0, D = 2^n for n=1..9. A period is legal iff period == D and high time == D/2 exactly.
- Input path: `sig_in` → SYNC_STAGES flops → `s_prev` flop; `rise` = last sync flop & ~`s_prev`.
- `per_cnt` (11 bit): loads 1 on `rise`, else increments, saturating at TIMEOUT. On `rise`, the pre-load value is the measured period.
- `hi_cnt` (10 bit): loads 1 on `rise`; increments while synced signal is high; holds while low. On `rise`, the pre-load value is the measured high time.
- Classification on each `rise` (combinational): `match`, `code` (0..9).
- States: IDLE, FIRST, CONFIRM, LOCKED. `cand` is a 4-bit candidate register.
  - IDLE: on `rise` → FIRST (start counting; no classification).
  - FIRST: on `rise`: match → `cand`=code, `err`=0, → CONFIRM; else `err`=1, stay FIRST.
  - CONFIRM: on `rise`: match & code==`cand` → LOCKED, `n_out`=code, `valid`=1, `err`=0; match & code≠`cand` → `cand`=code, `err`=0, stay; no match → `err`=1, → FIRST.
  - LOCKED: on `rise`: match & same code → stay, `err`=0; match & new code → `valid`=0, `cand`=code, → CONFIRM; no match → `valid`=0, `err`=1, → FIRST.
  - Any non-IDLE state with `per_cnt` == TIMEOUT and no `rise` → IDLE, `valid`=0, `err`=0. Timeout has priority only when no `rise` is present in that cycle.
- Lock requires two consecutive identical legal periods, which means three rising edges.
- Reset values: state IDLE, `n_out`=0, `valid`=0, `err`=0, `no_signal`=1, `cand`=0, counters 0, sync flops 0. Reset mid-lock returns to these values on the next edge.

## Timing
- All outputs are registered. `no_signal` is decoded from the registered state.
- Edge latency: a `sig_in` rise first sampled at edge E produces `rise` in the cycle after edge E+SYNC_STAGES−1. State and outputs update at edge E+SYNC_STAGES.
- Lock latency: the first three rises of a legal wave, sampled at edges E0, E0+D and E0+2D, give `valid`=1 after edge E0+2D+SYNC_STAGES.
- Loss of lock: `valid` falls at the same edge as the first non-matching rise is processed, i.e. SYNC_STAGES cycles after sampling.
- D=2 with SYNC_STAGES=2 must lock. Alternate-cycle toggling passes through the synchronizer.

## Test plan
- Reset, then drive an ideal D=16 wave with the first rise at edge 0 → `valid`=1 and `n_out`=4 after edge 34; `no_signal` falls after edge 2; `err`=0 throughout.
- Instantiate `n_divider` with n=0 driving `sig_in` on the same clk → lock to `n_out`=0 (D=20); sweep n=1..9 with resets between steps → `n_out`=n each time, including n=1 (D=2).
- Locked at D=64, switch to ideal D=8 → `valid` drops on the first D=8 rise, and after two more D=8 periods `valid`=1 and `n_out`=3.
- Periods of 16 with high time 5 → `err`=1 and `valid`=0 from the second rise onward, state stays FIRST. Then a legal D=32 wave → `err` clears, and lock is reached at `n_out`=5.
- Locked at D=512, then hold `sig_in` low → `valid`=0, `no_signal`=1 exactly when `per_cnt` reaches 1023, `n_out` still 9.
- Assert `rst` for one cycle while LOCKED → next edge gives `valid`=0, `n_out`=0, `no_signal`=1, and re-lock follows the normal three-rise latency.

Source files
------------

// File: rtl/n_ratio_detector.sv
// Recovers the n_divider ratio code from a divided square wave by measuring
// period and high time between rising edges, with lock, error and timeout status.
module n_ratio_detector #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_in,
  output logic [3:0] n_out,
  output logic       valid,
  output logic       err,
  output logic       no_signal
);

  // state   | meaning
  // IDLE    | no signal seen since reset or timeout
  // FIRST   | counting started, waiting for a first legal period
  // CONFIRM | one legal period seen, cand holds its code
  // LOCKED  | two consecutive identical legal periods, n_out valid
  typedef enum logic [1:0] {IDLE, FIRST, CONFIRM, LOCKED} state_t;

  localparam logic [10:0] TMO = 11'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_sync;
  logic                   s_prev;
  logic                   rise;
  logic [10:0]            per_cnt;
  logic [9:0]             hi_cnt;
  logic [3:0]             cand;
  logic                   match;
  logic [3:0]             code;
  state_t                 state;

  assign s_sync    = sync[SYNC_STAGES-1];
  assign rise      = s_sync & ~s_prev;
  assign no_signal = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '0;
      s_prev <= 1'b0;
    end else begin
      sync[0] <= sig_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      s_prev <= s_sync;
    end
  end

  // Both counters restart at 1 on a rise, so their pre-load values are the
  // measured period and high time in clk cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= 11'd1;
      hi_cnt  <= 10'd1;
    end else begin
      if (per_cnt != TMO) per_cnt <= per_cnt + 11'd1;
      if (s_sync && hi_cnt != '1) hi_cnt <= hi_cnt + 10'd1;
    end
  end

  always_comb begin
    match = 1'b0;
    code  = 4'd0;
    if (per_cnt == 11'd20 && hi_cnt == 10'd10) begin
      match = 1'b1;
      code  = 4'd0;
    end
    for (int i = 1; i <= 9; i++) begin
      if (per_cnt == (11'd1 << i) && hi_cnt == (10'd1 << (i - 1))) begin
        match = 1'b1;
        code  = 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n_out <= 4'd0;
      valid <= 1'b0;
      err   <= 1'b0;
      cand  <= 4'd0;
    end else if (rise) begin
      case (state)
        IDLE: state <= FIRST;
        FIRST: begin
          if (match) begin
            cand  <= code;
            err   <= 1'b0;
            state <= CONFIRM;
          end else begin
            err <= 1'b1;
          end
        end
        CONFIRM: begin
          if (match && code == cand) begin
            n_out <= code;
            valid <= 1'b1;
            err   <= 1'b0;
            state <= LOCKED;
          end else if (match) begin
            cand <= code;
            err  <= 1'b0;
          end else begin
            err   <= 1'b1;
            state <= FIRST;
          end
        end
        LOCKED: begin
          if (match && code == n_out) begin
            err <= 1'b0;
          end else if (match) begin
            valid <= 1'b0;
            cand  <= code;
            err   <= 1'b0;
            state <= CONFIRM;
          end else begin
            valid <= 1'b0;
            err   <= 1'b1;
            state <= FIRST;
          end
        end
        default: state <= IDLE;
      endcase
    end else if (state != IDLE && per_cnt == TMO) begin
      valid <= 1'b0;
      err   <= 1'b0;
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_n_ratio_detector.sv
// Directed bench for n_ratio_detector: ideal and malformed waves, lock/relock,
// timeout and mid-lock reset, with hand-computed expected cycle positions.
module tb_n_ratio_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       sig_in;
  logic [3:0] n_out;
  logic       valid;
  logic       err;
  logic       no_signal;

  int total = 0;
  int fails = 0;
  int ph    = 0;

  n_ratio_detector #(.SYNC_STAGES(2), .TIMEOUT(1023)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .n_out     (n_out),
    .valid     (valid),
    .err       (err),
    .no_signal (no_signal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Each call consumes n clock edges; sig_in set before edge k is sampled at edge k.
  task automatic drive(input int d, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = ((ph % d) < h);
      tick();
      ph++;
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    sig_in = 1'b0;
    tick();
    rst = 1'b0;
    ph  = 0;
  endtask

  initial begin
    int d;
    rst    = 1'b1;
    sig_in = 1'b0;
    tick();
    tick();
    chk("reset_n_out", 32'(n_out), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_no_signal", 32'(no_signal), 1);
    rst = 1'b0;
    ph  = 0;

    // ideal D=16, first rise at edge 0
    drive(16, 8, 2);
    chk("d16_nosig_e1", 32'(no_signal), 1);
    drive(16, 8, 1);
    chk("d16_nosig_e2", 32'(no_signal), 0);
    drive(16, 8, 31);
    chk("d16_valid_e33", 32'(valid), 0);
    chk("d16_err_e33", 32'(err), 0);
    drive(16, 8, 1);
    chk("d16_valid_e34", 32'(valid), 1);
    chk("d16_n_e34", 32'(n_out), 4);
    chk("d16_err_e34", 32'(err), 0);

    // sweep every legal ratio
    for (int n = 0; n <= 9; n++) begin
      d = (n == 0) ? 20 : (1 << n);
      do_reset();
      drive(d, d / 2, 2 * d + 2);
      chk($sformatf("sweep%0d_prelock", n), 32'(valid), 0);
      drive(d, d / 2, 1);
      chk($sformatf("sweep%0d_valid", n), 32'(valid), 1);
      chk($sformatf("sweep%0d_n", n), 32'(n_out), 32'(n));
    end

    // D=64 lock, then switch to D=8 at a rise (edge F=192)
    do_reset();
    drive(64, 32, 131);
    chk("d64_valid", 32'(valid), 1);
    chk("d64_n", 32'(n_out), 6);
    drive(64, 32, 61);
    ph = 0;
    drive(8, 4, 10);
    chk("sw_valid_F9", 32'(valid), 1);
    drive(8, 4, 1);
    chk("sw_valid_F10", 32'(valid), 0);
    chk("sw_n_hold_F10", 32'(n_out), 6);
    drive(8, 4, 7);
    chk("sw_valid_F17", 32'(valid), 0);
    drive(8, 4, 1);
    chk("sw_valid_F18", 32'(valid), 1);
    chk("sw_n_F18", 32'(n_out), 3);

    // period 16, high 5: error from second rise, then legal D=32 from edge G=64
    do_reset();
    drive(16, 5, 18);
    chk("bad_err_e17", 32'(err), 0);
    drive(16, 5, 1);
    chk("bad_err_e18", 32'(err), 1);
    chk("bad_valid_e18", 32'(valid), 0);
    chk("bad_nosig_e18", 32'(no_signal), 0);
    drive(16, 5, 32);
    chk("bad_err_e50", 32'(err), 1);
    chk("bad_valid_e50", 32'(valid), 0);
    drive(16, 5, 13);
    ph = 0;
    drive(32, 16, 34);
    chk("rec_err_G33", 32'(err), 1);
    drive(32, 16, 1);
    chk("rec_err_G34", 32'(err), 0);
    chk("rec_valid_G34", 32'(valid), 0);
    drive(32, 16, 31);
    chk("rec_valid_G65", 32'(valid), 0);
    drive(32, 16, 1);
    chk("rec_valid_G66", 32'(valid), 1);
    chk("rec_n_G66", 32'(n_out), 5);

    // D=512 lock, then hold low until timeout
    do_reset();
    drive(512, 256, 1027);
    chk("d512_valid", 32'(valid), 1);
    chk("d512_n", 32'(n_out), 9);
    drive(1, 0, 1022);
    chk("tmo_valid_before", 32'(valid), 1);
    chk("tmo_nosig_before", 32'(no_signal), 0);
    drive(1, 0, 1);
    chk("tmo_valid", 32'(valid), 0);
    chk("tmo_nosig", 32'(no_signal), 1);
    chk("tmo_n_hold", 32'(n_out), 9);
    chk("tmo_err", 32'(err), 0);

    // one-cycle reset while locked at D=4
    do_reset();
    drive(4, 2, 11);
    chk("d4_valid", 32'(valid), 1);
    chk("d4_n", 32'(n_out), 2);
    do_reset();
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_n", 32'(n_out), 0);
    chk("mid_rst_nosig", 32'(no_signal), 1);
    drive(4, 2, 10);
    chk("relock_pre", 32'(valid), 0);
    drive(4, 2, 1);
    chk("relock_valid", 32'(valid), 1);
    chk("relock_n", 32'(n_out), 2);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
